// File: rtl/addsub_pkg.sv
// Shared types and defaults for the word-serial add/sub controller.
// ADDSUB_OVF_EN (optional) enables the signed-overflow output.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam int ADDSUB_N_DEF     = 4;
  localparam int ADDSUB_WORDS_DEF = 4;

  // Word index never collapses to zero bits, even for a single-word operand.
  function automatic int addsub_idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Start/result handshake bundle for addsub_seq_ctrl; ovf exists only with ADDSUB_OVF_EN.
// slave = the controller side, master = the requester/consumer side.
interface addsub_seq_ctrl_if
  import addsub_pkg::*;
#(
  parameter int N     = ADDSUB_N_DEF,
  parameter int WORDS = ADDSUB_WORDS_DEF
);
  logic                 start_valid;
  logic                 start_ready;
  logic                 M;
  logic [N*WORDS-1:0]   A;
  logic [N*WORDS-1:0]   B;
  logic                 res_valid;
  logic                 res_ready;
  logic [N*WORDS-1:0]   S;
  logic                 Cout;
  logic                 busy;
`ifdef ADDSUB_OVF_EN
  logic                 ovf;
`endif

  modport slave (
    input  start_valid, M, A, B, res_ready,
`ifdef ADDSUB_OVF_EN
    output ovf,
`endif
    output start_ready, res_valid, S, Cout, busy
  );

  modport master (
    output start_valid, M, A, B, res_ready,
`ifdef ADDSUB_OVF_EN
    input  ovf,
`endif
    input  start_ready, res_valid, S, Cout, busy
  );
endinterface

// File: rtl/addsub_slice.sv
// Combinational N-bit ripple add/sub slice: sum = a + (b ^ m) + cin.
// msb_cin is the carry into the top bit, used for signed overflow.
module addsub_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         m,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);
  logic [N:0]   c;
  logic [N-1:0] bx;

  always_comb begin
    bx   = b ^ {N{m}};
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < N; k++) begin
      sum[k]   = a[k] ^ bx[k] ^ c[k];
      c[k+1]   = (a[k] & bx[k]) | (c[k] & (a[k] ^ bx[k]));
    end
  end

  assign cout    = c[N];
  assign msb_cin = c[N-1];
endmodule

// File: rtl/addsub_seq_ctrl.sv
// Word-serial add/sub: one N-bit word per cycle, result WORDS cycles after accept,
// held in DONE until res_ready. ADDSUB_OVF_EN adds a registered signed-overflow flag.
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int N     = ADDSUB_N_DEF,
  parameter int WORDS = ADDSUB_WORDS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_seq_ctrl_if.slave    bus
);
  localparam int IW = addsub_idx_w(WORDS);

  addsub_state_t                state;
  logic [IW-1:0]                idx;
  logic [WORDS-1:0][N-1:0]      a_q;
  logic [WORDS-1:0][N-1:0]      b_q;
  logic [WORDS-1:0][N-1:0]      s_q;
  logic                         m_q;
  logic                         carry_q;
  logic                         cout_q;
  logic                         start_ready_q;
  logic                         res_valid_q;
  logic                         busy_q;

  logic [N-1:0] sum_w;
  logic         cin_w;
  logic         cout_w;
  logic         msb_cin_w;

  assign cin_w = (idx == '0) ? m_q : carry_q;

  addsub_slice #(.N(N)) u_slice (
    .a       (a_q[idx]),
    .b       (b_q[idx]),
    .m       (m_q),
    .cin     (cin_w),
    .sum     (sum_w),
    .cout    (cout_w),
    .msb_cin (msb_cin_w)
  );

`ifdef ADDSUB_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (state == RUN && idx == IW'(WORDS - 1))
      ovf_q <= msb_cin_w ^ cout_w;
  end
  assign bus.ovf = ovf_q;
`else
  logic msb_cin_unused;
  assign msb_cin_unused = msb_cin_w;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      s_q           <= '0;
      m_q           <= 1'b0;
      carry_q       <= 1'b0;
      cout_q        <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid && start_ready_q) begin
            a_q           <= bus.A;
            b_q           <= bus.B;
            m_q           <= bus.M;
            idx           <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          s_q[idx] <= sum_w;
          carry_q  <= cout_w;
          if (idx == IW'(WORDS - 1)) begin
            cout_q      <= cout_w;
            res_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE here keeps start_ready low during the handshake cycle.
          if (bus.res_ready) begin
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.busy        = busy_q;
  assign bus.S           = s_q;
  assign bus.Cout        = cout_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Scoreboard bench for addsub_seq_ctrl (N=4, WORDS=4); ovf checked when ADDSUB_OVF_EN is defined.
module tb_addsub_seq_ctrl;
  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_seq_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();
  addsub_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    logic [W:0]   full;
    logic [W-1:0] bx;
    exp_t         r;
    bx   = m ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + (W+1)'(m);
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.v  = (a[W-1] == bx[W-1]) && (r.s[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input int stall);
    exp_t e;
    int   cyc;
    @(negedge clk);
    chk("start_ready_idle", 32'(bus.start_ready), 32'd1);
    sb.push_back(model(a, b, m));
    bus.A = a; bus.B = b; bus.M = m; bus.start_valid = 1'b1; bus.res_ready = 1'b0;
    @(negedge clk);
    // Garbage on the operand inputs must not disturb the running operation.
    bus.start_valid = 1'b0; bus.A = W'($urandom); bus.B = W'($urandom); bus.M = ~m;
    chk("busy_run", 32'(bus.busy), 32'd1);
    chk("start_ready_run", 32'(bus.start_ready), 32'd0);
    cyc = 0;
    while (!bus.res_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(WORDS));
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    chk("S", 32'(bus.S), 32'(e.s));
    chk("Cout", 32'(bus.Cout), 32'(e.c));
`ifdef ADDSUB_OVF_EN
    chk("ovf", 32'(bus.ovf), 32'(e.v));
`endif
    for (int i = 0; i < stall; i++) begin
      bus.start_valid = (i % 2 == 0);
      bus.A = W'($urandom); bus.B = W'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_S", 32'(bus.S), 32'(e.s));
      chk("hold_Cout", 32'(bus.Cout), 32'(e.c));
      chk("hold_start_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("valid_drop", 32'(bus.res_valid), 32'd0);
    chk("ready_back", 32'(bus.start_ready), 32'd1);
    chk("busy_drop", 32'(bus.busy), 32'd0);
  endtask

  task automatic reset_mid_run();
    int seen;
    @(negedge clk);
    bus.A = 16'h1111; bus.B = 16'h2222; bus.M = 1'b0; bus.start_valid = 1'b1;
    @(negedge clk);   // accepted; word 0 in flight
    bus.start_valid = 1'b0;
    @(negedge clk);   // word 1
    @(negedge clk);   // word 2
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_run_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_run_S", 32'(bus.S), 32'd0);
    chk("rst_run_Cout", 32'(bus.Cout), 32'd0);
    chk("rst_run_busy", 32'(bus.busy), 32'd0);
    chk("rst_run_start_ready", 32'(bus.start_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    chk("rst_run_no_result", 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.M           = 1'b0;
    bus.A           = '0;
    bus.B           = '0;
    rst_n           = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_S", 32'(bus.S), 32'd0);
    chk("rst_Cout", 32'(bus.Cout), 32'd0);
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
`ifdef ADDSUB_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst_n = 1'b1;

    do_op(16'h1234, 16'h0FFF, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(16'hABCD, 16'h1357, 1'b1, 5);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 0);
    do_op(16'h0000, 16'h0000, 1'b1, 1);
    for (int i = 0; i < 6; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    reset_mid_run();
    do_op(16'h0F0F, 16'h00F1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
